diamond_display: RTL

Consumer of the sticky per-diamond eaten flags produced by the blue/red diamond collision detectors. Each frame it renders the six level diamonds from the VGA beam position and plays a blink-out animation when a diamond is eaten. It also keeps per-colour collected counts and raises a level-complete flag for the door/exit logic. It sits between the collision detectors and the colour mapper.

---
 rtl/diamond_pkg.sv | 15 +
 rtl/diamond_display_if.sv | 12 +
 rtl/diamond_slot.sv | 65 ++++++
 rtl/diamond_display.sv | 124 ++++++++++++
 4 files changed

// File: rtl/diamond_pkg.sv
// Shared constants and types for the level diamond renderer: box geometry,
// corner tables (0..2 blue, 3..5 red) and the per-diamond lifecycle states.
package diamond_pkg;

    localparam int DIAMOND_SIZE = 20;
    localparam int NUM_DIAMONDS = 6;

    localparam logic [9:0] DIAMOND_LEFT [NUM_DIAMONDS] =
        '{10'd460, 10'd366, 10'd38, 10'd330, 10'd300, 10'd190};
    localparam logic [9:0] DIAMOND_TOP  [NUM_DIAMONDS] =
        '{10'd408, 10'd238, 10'd90, 10'd408, 10'd220, 10'd42};

    typedef enum logic [1:0] {SHOW, VANISH, GONE} diamond_state_t;

endpackage

// File: rtl/diamond_display_if.sv
// Pixel bus between the beam generator and the diamond renderer: beam
// position in, registered sprite lookup out.
interface diamond_display_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       is_diamond;
    logic       diamond_red;
    logic [8:0] sprite_addr;

    modport master (output DrawX, DrawY, input is_diamond, diamond_red, sprite_addr);
    modport slave  (input DrawX, DrawY, output is_diamond, diamond_red, sprite_addr);
endinterface

// File: rtl/diamond_slot.sv
// One diamond: SHOW/VANISH/GONE lifecycle with frame-counted blink-out, plus
// the 20x20 hit test and local sprite address for the current beam position.
module diamond_slot
    import diamond_pkg::*;
#(
    parameter logic [9:0] LEFT          = 10'd0,
    parameter logic [9:0] TOP           = 10'd0,
    parameter int         VANISH_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       eat,
    input  logic       tick,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       visible_hit,
    output logic [8:0] local_addr,
    output logic       entered_vanish
);

    diamond_state_t state, state_nxt;
    logic [3:0]     vcnt, vcnt_nxt;
    logic [9:0]     dx, dy;
    logic           in_box, visible;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= SHOW;
            vcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            vcnt  <= vcnt_nxt;
        end
    end

    // A tick arriving together with the eat is swallowed: entry always starts at 0.
    always_comb begin
        state_nxt      = state;
        vcnt_nxt       = vcnt;
        entered_vanish = 1'b0;
        case (state)
            SHOW: if (eat) begin
                state_nxt      = VANISH;
                vcnt_nxt       = 4'd0;
                entered_vanish = 1'b1;
            end
            VANISH: if (tick) begin
                if (vcnt == 4'(VANISH_FRAMES - 1)) state_nxt = GONE;
                else                               vcnt_nxt  = vcnt + 4'd1;
            end
            default: ;
        endcase
    end

    assign visible = (state == SHOW) || (state == VANISH && !vcnt[0]);

    assign dx     = DrawX - LEFT;
    assign dy     = DrawY - TOP;
    assign in_box = (DrawX >= LEFT) && (DrawX < LEFT + 10'(DIAMOND_SIZE)) &&
                    (DrawY >= TOP)  && (DrawY < TOP  + 10'(DIAMOND_SIZE));

    assign visible_hit = visible && in_box;
    assign local_addr  = 9'(dy[4:0]) * 9'd20 + 9'(dx[4:0]);

endmodule

// File: rtl/diamond_display.sv
// Renders the six level diamonds, blinks them out when eaten, counts them per
// colour and flags level completion. Optional idle sparkle: DIAMOND_SPARKLE_EN.
module diamond_display
    import diamond_pkg::*;
#(
    parameter int VANISH_FRAMES = 8,
    parameter int SPARKLE_DIV   = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [2:0]         eat_blue,
    input  logic [2:0]         eat_red,
    diamond_display_if.slave   pix,
    output logic [1:0]         sparkle_phase,
    output logic [1:0]         blue_count,
    output logic [1:0]         red_count,
    output logic               all_collected
);

    if (VANISH_FRAMES < 2 || VANISH_FRAMES > 15) begin : g_bad_vanish
        $error("VANISH_FRAMES out of range");
    end
    if (SPARKLE_DIV < 1 || SPARKLE_DIV > 16) begin : g_bad_div
        $error("SPARKLE_DIV out of range");
    end

    logic                               frame_prev, tick;
    logic [NUM_DIAMONDS-1:0]            eat_vec, vis, entered;
    logic [NUM_DIAMONDS-1:0][8:0]       addr;
    logic                               hit_n, red_n;
    logic [8:0]                         addr_n;
    logic [2:0]                         blue_sum, red_sum;

    // Previous value resets high so a strobe already high out of reset is not an edge.
    always_ff @(posedge Clk) begin
        if (Reset) frame_prev <= 1'b1;
        else       frame_prev <= frame_clk;
    end
    assign tick    = frame_clk && !frame_prev;
    assign eat_vec = {eat_red, eat_blue};

    for (genvar g = 0; g < NUM_DIAMONDS; g++) begin : g_slot
        diamond_slot #(
            .LEFT          (DIAMOND_LEFT[g]),
            .TOP           (DIAMOND_TOP[g]),
            .VANISH_FRAMES (VANISH_FRAMES)
        ) u_slot (
            .Clk            (Clk),
            .Reset          (Reset),
            .eat            (eat_vec[g]),
            .tick           (tick),
            .DrawX          (pix.DrawX),
            .DrawY          (pix.DrawY),
            .visible_hit    (vis[g]),
            .local_addr     (addr[g]),
            .entered_vanish (entered[g])
        );
    end

    // Walk from the highest index down so the lowest visible index wins.
    always_comb begin
        hit_n  = 1'b0;
        red_n  = 1'b0;
        addr_n = 9'd0;
        for (int i = NUM_DIAMONDS - 1; i >= 0; i--) begin
            if (vis[i]) begin
                hit_n  = 1'b1;
                red_n  = (i >= NUM_DIAMONDS / 2);
                addr_n = addr[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix.is_diamond  <= 1'b0;
            pix.diamond_red <= 1'b0;
            pix.sprite_addr <= 9'd0;
        end else begin
            pix.is_diamond  <= hit_n;
            pix.diamond_red <= red_n;
            pix.sprite_addr <= addr_n;
        end
    end

    assign blue_sum = 3'(blue_count) + 3'(entered[0]) + 3'(entered[1]) + 3'(entered[2]);
    assign red_sum  = 3'(red_count)  + 3'(entered[3]) + 3'(entered[4]) + 3'(entered[5]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            blue_count    <= 2'd0;
            red_count     <= 2'd0;
            all_collected <= 1'b0;
        end else begin
            blue_count    <= (blue_sum > 3'd3) ? 2'd3 : blue_sum[1:0];
            red_count     <= (red_sum  > 3'd3) ? 2'd3 : red_sum[1:0];
            all_collected <= (blue_count == 2'd3) && (red_count == 2'd3);
        end
    end

`ifdef DIAMOND_SPARKLE_EN
    logic [3:0] div_cnt;
    logic [1:0] phase;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= 4'd0;
            phase   <= 2'd0;
        end else if (tick) begin
            if (div_cnt == 4'(SPARKLE_DIV - 1)) begin
                div_cnt <= 4'd0;
                phase   <= phase + 2'd1;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end
    assign sparkle_phase = phase;
`else
    assign sparkle_phase = 2'd0;
`endif

endmodule
